seven_stage_mem_port_arbiter: RTL and testbench

- Shares one memory port between the seven-stage core's fetch-issue and memory-issue stages.
- Single outstanding transaction; responses return in order.
- Drives `i_mem_issue_hazard`, `i_mem_recv_hazard`, `d_mem_issue_hazard` and `d_mem_recv_hazard` into the seven-stage stall unit.
- Data requests have priority; a starvation counter guarantees fetch progress.
- Drops responses of fetches squashed by a flush.

---
 rtl/seven_stage_mem_port_arbiter_if.sv | 47 ++++
 rtl/seven_stage_mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_seven_stage_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/seven_stage_mem_port_arbiter_if.sv
// Core-side and memory-side signals for the shared memory port.
// slave = arbiter view, master = environment (core + memory) view.
interface seven_stage_mem_port_arbiter_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32
);
    logic                      i_req;
    logic [ADDRESS_BITS-1:0]   i_addr;
    logic                      i_flush;
    logic                      d_req;
    logic                      d_write;
    logic [ADDRESS_BITS-1:0]   d_addr;
    logic [DATA_WIDTH-1:0]     d_wdata;
    logic [DATA_WIDTH/8-1:0]   d_byte_en;
    logic                      mem_req;
    logic                      mem_write;
    logic [ADDRESS_BITS-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_byte_en;
    logic                      mem_ready;
    logic                      mem_resp_valid;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic                      i_resp_valid;
    logic [DATA_WIDTH-1:0]     i_rdata;
    logic                      d_resp_valid;
    logic [DATA_WIDTH-1:0]     d_rdata;
    logic                      i_mem_issue_hazard;
    logic                      d_mem_issue_hazard;
    logic                      i_mem_recv_hazard;
    logic                      d_mem_recv_hazard;

    modport slave (
        input  i_req, i_addr, i_flush, d_req, d_write, d_addr, d_wdata, d_byte_en,
               mem_ready, mem_resp_valid, mem_rdata,
        output mem_req, mem_write, mem_addr, mem_wdata, mem_byte_en,
               i_resp_valid, i_rdata, d_resp_valid, d_rdata,
               i_mem_issue_hazard, d_mem_issue_hazard, i_mem_recv_hazard, d_mem_recv_hazard
    );

    modport master (
        output i_req, i_addr, i_flush, d_req, d_write, d_addr, d_wdata, d_byte_en,
               mem_ready, mem_resp_valid, mem_rdata,
        input  mem_req, mem_write, mem_addr, mem_wdata, mem_byte_en,
               i_resp_valid, i_rdata, d_resp_valid, d_rdata,
               i_mem_issue_hazard, d_mem_issue_hazard, i_mem_recv_hazard, d_mem_recv_hazard
    );
endinterface

// File: rtl/seven_stage_mem_port_arbiter.sv
// Purpose: shares one memory port between fetch and data, data first, fetch forced after STARVE_LIMIT data wins.
// Latency: request mux is combinational in IDLE; responses pass through combinationally; one transaction outstanding.
// Backpressure: mem_ready low holds the request and raises the issue hazard; nothing new issues until the response.
module seven_stage_mem_port_arbiter #(
    parameter int CORE            = 0,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_BITS    = 32,
    parameter int STARVE_LIMIT    = 4,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic scan,
    seven_stage_mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, I_OUT, D_OUT, I_DROP} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [31:0] cycle_q, cycle_d;

    logic i_pend, grant_i, grant_d, idle;

    assign idle    = (state_q == IDLE);
    assign i_pend  = bus.i_req & ~bus.i_flush;
    assign grant_i = i_pend & (~bus.d_req | (starve_cnt_q == LIMIT));
    assign grant_d = bus.d_req & ~grant_i;
    assign cycle_d = cycle_q + 32'd1;

    always_comb begin
        state_d          = state_q;
        starve_cnt_d     = starve_cnt_q;
        bus.mem_req      = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        bus.mem_byte_en  = '0;
        bus.i_resp_valid = 1'b0;
        bus.i_rdata      = '0;
        bus.d_resp_valid = 1'b0;
        bus.d_rdata      = '0;
        unique case (state_q)
            IDLE: begin
                bus.mem_req = grant_i | grant_d;
                if (grant_i) begin
                    bus.mem_addr    = bus.i_addr;
                    bus.mem_byte_en = '1;
                end else if (grant_d) begin
                    bus.mem_write   = bus.d_write;
                    bus.mem_addr    = bus.d_addr;
                    bus.mem_wdata   = bus.d_wdata;
                    bus.mem_byte_en = bus.d_byte_en;
                end
                if (!bus.i_req) starve_cnt_d = 4'd0;
                if (bus.mem_ready && grant_i) begin
                    state_d      = I_OUT;
                    starve_cnt_d = 4'd0;
                end else if (bus.mem_ready && grant_d) begin
                    state_d = D_OUT;
                    if (i_pend && starve_cnt_q < LIMIT) starve_cnt_d = starve_cnt_q + 4'd1;
                end
            end
            I_OUT: begin
                // A flush landing with the response still kills it: the fetch is stale.
                if (bus.mem_resp_valid) begin
                    state_d          = IDLE;
                    bus.i_resp_valid = ~bus.i_flush;
                    bus.i_rdata      = bus.i_flush ? '0 : bus.mem_rdata;
                end else if (bus.i_flush) begin
                    state_d = I_DROP;
                end
            end
            I_DROP: begin
                if (bus.mem_resp_valid) state_d = IDLE;
            end
            D_OUT: begin
                if (bus.mem_resp_valid) begin
                    state_d          = IDLE;
                    bus.d_resp_valid = 1'b1;
                    bus.d_rdata      = bus.mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.i_mem_issue_hazard = i_pend & ~(idle & grant_i & bus.mem_ready);
    assign bus.d_mem_issue_hazard = bus.d_req & ~(idle & grant_d & bus.mem_ready);
    assign bus.i_mem_recv_hazard  = (state_q == I_OUT) & ~bus.mem_resp_valid;
    assign bus.d_mem_recv_hazard  = (state_q == D_OUT) & ~bus.mem_resp_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
            cycle_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            cycle_q      <= cycle_d;
        end
    end

`ifndef SYNTHESIS
    logic in_window;
    assign in_window = ($signed({1'b0, cycle_q}) >= 33'(SCAN_CYCLES_MIN)) &&
                       ($signed({1'b0, cycle_q}) <= 33'(SCAN_CYCLES_MAX));

    always @(posedge clock) begin
        if (scan && in_window)
            $display("core=%0d cycle=%0d state=%0d starve=%0d ih=%b/%b dh=%b/%b",
                     CORE, cycle_q, state_q, starve_cnt_q,
                     bus.i_mem_issue_hazard, bus.i_mem_recv_hazard,
                     bus.d_mem_issue_hazard, bus.d_mem_recv_hazard);
    end
`endif
endmodule

// File: tb/tb_seven_stage_mem_port_arbiter.sv
// Directed bench for the fetch/data memory port arbiter: inputs driven 1ns after
// the rising edge, outputs sampled on the falling edge against hand-computed values.
module tb_seven_stage_mem_port_arbiter;
    logic clock = 1'b0;
    logic reset;
    logic scan;
    int   errors = 0;
    int   checks = 0;

    seven_stage_mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDRESS_BITS(32)) bus ();

    seven_stage_mem_port_arbiter #(
        .CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(32), .STARVE_LIMIT(4),
        .SCAN_CYCLES_MIN(0), .SCAN_CYCLES_MAX(1000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .scan(scan),
        .bus(bus.slave)
    );

    always #5 clock = ~clock;

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_req = 0; bus.i_addr = '0; bus.i_flush = 0;
        bus.d_req = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_byte_en = '0;
        bus.mem_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        reset = 0; scan = 0;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1 reset = 1;
        @(negedge clock);
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        checks++; if ({bus.i_mem_issue_hazard, bus.i_mem_recv_hazard, bus.d_mem_issue_hazard, bus.d_mem_recv_hazard} !== 4'b0)
            begin errors++; $display("FAIL reset_hazards: got %b want 0000",
                {bus.i_mem_issue_hazard, bus.i_mem_recv_hazard, bus.d_mem_issue_hazard, bus.d_mem_recv_hazard}); end
        checks++; if ({bus.i_resp_valid, bus.d_resp_valid} !== 2'b0) begin errors++; $display("FAIL reset_resp: got %b want 00", {bus.i_resp_valid, bus.d_resp_valid}); end
    endtask

    task automatic test_fetch();
        next_cycle();
        bus.i_req = 1; bus.i_addr = 32'h100; bus.mem_ready = 1;
        @(negedge clock);
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL fetch_mem_req: got %b want 1", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL fetch_addr: got %h want 100", bus.mem_addr); end
        checks++; if ({bus.mem_write, bus.mem_byte_en} !== 5'b01111) begin errors++; $display("FAIL fetch_we_be: got %b want 01111", {bus.mem_write, bus.mem_byte_en}); end
        checks++; if (bus.i_mem_issue_hazard !== 1'b0) begin errors++; $display("FAIL fetch_issue_hz: got %b want 0", bus.i_mem_issue_hazard); end
        next_cycle();
        bus.i_req = 0;
        @(negedge clock);
        checks++; if (bus.i_mem_recv_hazard !== 1'b1) begin errors++; $display("FAIL fetch_recv_hz_wait: got %b want 1", bus.i_mem_recv_hazard); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL fetch_no_second_req: got %b want 0", bus.mem_req); end
        next_cycle();
        bus.mem_resp_valid = 1; bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clock);
        checks++; if (bus.i_resp_valid !== 1'b1) begin errors++; $display("FAIL fetch_resp_valid: got %b want 1", bus.i_resp_valid); end
        checks++; if (bus.i_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata: got %h want deadbeef", bus.i_rdata); end
        checks++; if (bus.i_mem_recv_hazard !== 1'b0) begin errors++; $display("FAIL fetch_recv_hz_resp: got %b want 0", bus.i_mem_recv_hazard); end
        next_cycle();
        bus.mem_resp_valid = 0;
        @(negedge clock);
        checks++; if (bus.i_mem_recv_hazard !== 1'b0) begin errors++; $display("FAIL fetch_recv_hz_after: got %b want 0", bus.i_mem_recv_hazard); end
    endtask

    task automatic test_starvation();
        logic exp_i;
        for (int k = 0; k < 6; k++) begin
            exp_i = (k == 4);
            next_cycle();
            bus.i_req = 1; bus.i_addr = 32'h1000; bus.d_req = 1; bus.d_addr = 32'h2000;
            bus.d_write = 0; bus.d_byte_en = 4'hF; bus.mem_ready = 1; bus.mem_resp_valid = 0;
            @(negedge clock);
            checks++; if (bus.mem_addr !== (exp_i ? 32'h1000 : 32'h2000))
                begin errors++; $display("FAIL starve_grant_%0d: got addr %h want %h", k, bus.mem_addr, exp_i ? 32'h1000 : 32'h2000); end
            checks++; if (bus.i_mem_issue_hazard !== ~exp_i)
                begin errors++; $display("FAIL starve_i_hz_%0d: got %b want %b", k, bus.i_mem_issue_hazard, ~exp_i); end
            checks++; if (bus.d_mem_issue_hazard !== exp_i)
                begin errors++; $display("FAIL starve_d_hz_%0d: got %b want %b", k, bus.d_mem_issue_hazard, exp_i); end
            next_cycle();
            bus.mem_resp_valid = 1; bus.mem_rdata = 32'(k);
            @(negedge clock);
            checks++; if ({bus.i_resp_valid, bus.d_resp_valid} !== {exp_i, ~exp_i})
                begin errors++; $display("FAIL starve_resp_%0d: got %b want %b", k, {bus.i_resp_valid, bus.d_resp_valid}, {exp_i, ~exp_i}); end
            checks++; if (bus.i_mem_issue_hazard !== 1'b1)
                begin errors++; $display("FAIL starve_i_hz_busy_%0d: got %b want 1", k, bus.i_mem_issue_hazard); end
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_flush();
        next_cycle();
        bus.i_req = 1; bus.i_addr = 32'h200; bus.mem_ready = 1;
        @(negedge clock);
        checks++; if (bus.mem_addr !== 32'h200) begin errors++; $display("FAIL flush_issue_addr: got %h want 200", bus.mem_addr); end
        next_cycle();
        bus.i_req = 0; bus.i_flush = 1;
        @(negedge clock);
        checks++; if (bus.i_mem_recv_hazard !== 1'b1) begin errors++; $display("FAIL flush_recv_hz: got %b want 1", bus.i_mem_recv_hazard); end
        next_cycle();
        bus.i_flush = 0;
        @(negedge clock);
        checks++; if (bus.i_mem_recv_hazard !== 1'b0) begin errors++; $display("FAIL flush_drop_hz: got %b want 0", bus.i_mem_recv_hazard); end
        next_cycle();
        bus.mem_resp_valid = 1; bus.mem_rdata = 32'h0BAD0BAD;
        @(negedge clock);
        checks++; if (bus.i_resp_valid !== 1'b0) begin errors++; $display("FAIL flush_resp_dropped: got %b want 0", bus.i_resp_valid); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL flush_no_req_in_drop: got %b want 0", bus.mem_req); end
        next_cycle();
        bus.mem_resp_valid = 0; bus.d_req = 1; bus.d_addr = 32'h300; bus.d_byte_en = 4'hF;
        @(negedge clock);
        checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h300})
            begin errors++; $display("FAIL flush_next_data_issue: got req=%b addr=%h want req=1 addr=300", bus.mem_req, bus.mem_addr); end
        next_cycle();
        bus.d_req = 0; bus.mem_resp_valid = 1; bus.mem_rdata = 32'hCAFEF00D;
        @(negedge clock);
        checks++; if ({bus.d_resp_valid, bus.d_rdata} !== {1'b1, 32'hCAFEF00D})
            begin errors++; $display("FAIL flush_data_resp: got v=%b d=%h want v=1 d=cafef00d", bus.d_resp_valid, bus.d_rdata); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_flush_with_resp();
        next_cycle();
        bus.i_req = 1; bus.i_addr = 32'h240; bus.mem_ready = 1;
        next_cycle();
        bus.i_req = 0; bus.i_flush = 1; bus.mem_resp_valid = 1; bus.mem_rdata = 32'h11112222;
        @(negedge clock);
        checks++; if (bus.i_resp_valid !== 1'b0) begin errors++; $display("FAIL flush_same_cycle_resp: got %b want 0", bus.i_resp_valid); end
        next_cycle();
        bus.i_flush = 0; bus.mem_resp_valid = 0; bus.d_req = 1; bus.d_addr = 32'h340; bus.d_byte_en = 4'hF;
        @(negedge clock);
        checks++; if ({bus.mem_req, bus.d_mem_issue_hazard} !== 2'b10)
            begin errors++; $display("FAIL flush_same_cycle_idle: got req=%b hz=%b want req=1 hz=0", bus.mem_req, bus.d_mem_issue_hazard); end
        next_cycle();
        bus.d_req = 0; bus.mem_resp_valid = 1;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_store_backpressure();
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            bus.d_req = 1; bus.d_write = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'h12345678;
            bus.d_byte_en = 4'b0011; bus.mem_ready = 0;
            @(negedge clock);
            checks++; if (bus.d_mem_issue_hazard !== 1'b1) begin errors++; $display("FAIL store_stall_hz_%0d: got %b want 1", k, bus.d_mem_issue_hazard); end
        end
        next_cycle();
        bus.mem_ready = 1;
        @(negedge clock);
        checks++; if (bus.d_mem_issue_hazard !== 1'b0) begin errors++; $display("FAIL store_accept_hz: got %b want 0", bus.d_mem_issue_hazard); end
        checks++; if ({bus.mem_write, bus.mem_byte_en} !== 5'b10011) begin errors++; $display("FAIL store_we_be: got %b want 10011", {bus.mem_write, bus.mem_byte_en}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata} !== {32'h40, 32'h12345678})
            begin errors++; $display("FAIL store_addr_data: got %h/%h want 40/12345678", bus.mem_addr, bus.mem_wdata); end
        next_cycle();
        bus.d_req = 0; bus.d_write = 0; bus.mem_resp_valid = 1; bus.mem_rdata = '0;
        @(negedge clock);
        checks++; if (bus.d_resp_valid !== 1'b1) begin errors++; $display("FAIL store_ack: got %b want 1", bus.d_resp_valid); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid_transaction();
        next_cycle();
        bus.d_req = 1; bus.d_addr = 32'h80; bus.d_byte_en = 4'hF; bus.mem_ready = 1;
        next_cycle();
        bus.d_req = 0; bus.mem_ready = 0;
        @(negedge clock);
        checks++; if (bus.d_mem_recv_hazard !== 1'b1) begin errors++; $display("FAIL midrst_in_flight: got %b want 1", bus.d_mem_recv_hazard); end
        #1 reset = 0;
        #1;
        checks++; if ({bus.d_mem_recv_hazard, bus.mem_req, bus.d_resp_valid} !== 3'b000)
            begin errors++; $display("FAIL midrst_async_clear: got %b want 000", {bus.d_mem_recv_hazard, bus.mem_req, bus.d_resp_valid}); end
        next_cycle();
        reset = 1;
        next_cycle();
        bus.i_req = 1; bus.i_addr = 32'h500; bus.mem_ready = 1;
        @(negedge clock);
        checks++; if ({bus.mem_req, bus.mem_addr, bus.i_mem_issue_hazard} !== {1'b1, 32'h500, 1'b0})
            begin errors++; $display("FAIL midrst_fetch_grant: got req=%b addr=%h hz=%b want 1/500/0", bus.mem_req, bus.mem_addr, bus.i_mem_issue_hazard); end
        next_cycle();
        bus.i_req = 0; bus.mem_resp_valid = 1; bus.mem_rdata = 32'h55AA55AA;
        @(negedge clock);
        checks++; if ({bus.i_resp_valid, bus.i_rdata} !== {1'b1, 32'h55AA55AA})
            begin errors++; $display("FAIL midrst_fetch_resp: got v=%b d=%h want v=1 d=55aa55aa", bus.i_resp_valid, bus.i_rdata); end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_starvation();
        test_flush();
        test_flush_with_resp();
        test_store_backpressure();
        test_reset_mid_transaction();
        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
